// File: rtl/ct_fspu_wb_pkg.sv
// Shared constants for the FSPU writeback path: pipeline latency, default widths
// and the FIFO entry layout {gpr, preg, data} (gpr in the MSB, data in the LSBs).
package ct_fspu_wb_pkg;

    localparam int FSPU_LAT   = 2;
    localparam int PREG_W_DEF = 7;
    localparam int DATA_W_DEF = 64;

    function automatic int entry_w(input int preg_w, input int data_w);
        return 1 + preg_w + data_w;
    endfunction

endpackage

// File: rtl/ct_fspu_wb_fifo.sv
// Generic DEPTH x W FIFO with count/full/empty; a push that finds the FIFO full
// (and no same-cycle pop) is dropped and flagged on ovf.
module ct_fspu_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 72,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst_b,
    input  logic             push,
    input  logic [W-1:0]     wdata,
    input  logic             pop,
    output logic [W-1:0]     rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             ovf
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        pop_ok  = pop & ~empty;
        // A full FIFO can still take a push in the same cycle its head leaves.
        push_ok = push & (~full | pop_ok);
        ovf     = push & full & ~pop_ok;
        mem_d   = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ct_fspu_wb_ctrl.sv
// FSPU result receiver: tracks ops EX1->EX3, captures EX3 results into a FIFO,
// drains it to the writeback port and issues credits so the FIFO never overflows.
module ct_fspu_wb_ctrl
    import ct_fspu_wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int PREG_W = PREG_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              forever_cpuclk,
    input  logic              cpurst_b,
    input  logic              ex1_fspu_issue_vld,
    input  logic [PREG_W-1:0] ex1_fspu_dst_preg,
    input  logic              ex1_fspu_dst_gpr,
    input  logic              rtu_yy_flush,
    input  logic              fspu_forward_r_vld,
    input  logic [DATA_W-1:0] fspu_forward_result,
    input  logic [DATA_W-1:0] fspu_mfvr_data,
    output logic              fspu_issue_allow,
    output logic              fspu_wb_vld,
    output logic              fspu_wb_gpr,
    output logic [PREG_W-1:0] fspu_wb_preg,
    output logic [DATA_W-1:0] fspu_wb_data,
    input  logic              wb_fspu_grant,
    output logic              fspu_wb_err
);

    localparam int ENT_W = entry_w(PREG_W, DATA_W);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = $clog2(DEPTH + FSPU_LAT + 1);

    // Stage 0 is EX2, stage FSPU_LAT-1 is EX3.
    logic [FSPU_LAT-1:0]             trk_vld_q, trk_vld_d;
    logic [FSPU_LAT-1:0]             trk_gpr_q, trk_gpr_d;
    logic [FSPU_LAT-1:0][PREG_W-1:0] trk_preg_q, trk_preg_d;
    logic                            err_q, err_d;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full, fifo_empty, fifo_ovf;
    logic [ENT_W-1:0]  push_ent, head_ent;
    logic              push, pop, issue_ok, proto_err;
    logic              ex3_vld, ex3_gpr;
    logic [PREG_W-1:0] ex3_preg;
    logic [OCC_W-1:0]  occ;

    always_comb begin
        // Credit uses registered occupancy only; a pop frees its slot a cycle later.
        occ = OCC_W'(fifo_count);
        for (int i = 0; i < FSPU_LAT; i++) begin
            occ = occ + OCC_W'(trk_vld_q[i]);
        end
        fspu_issue_allow = ~fifo_full & (occ < OCC_W'(DEPTH));
        issue_ok         = ex1_fspu_issue_vld & fspu_issue_allow & ~rtu_yy_flush;

        ex3_vld  = trk_vld_q[FSPU_LAT-1];
        ex3_gpr  = trk_gpr_q[FSPU_LAT-1];
        ex3_preg = trk_preg_q[FSPU_LAT-1];

        trk_vld_d[0]  = issue_ok;
        trk_gpr_d[0]  = ex1_fspu_dst_gpr;
        trk_preg_d[0] = ex1_fspu_dst_preg;
        for (int i = 1; i < FSPU_LAT; i++) begin
            trk_vld_d[i]  = trk_vld_q[i-1];
            trk_gpr_d[i]  = trk_gpr_q[i-1];
            trk_preg_d[i] = trk_preg_q[i-1];
        end
        if (rtu_yy_flush) begin
            trk_vld_d = '0;
        end

        push     = ex3_vld & ~rtu_yy_flush;
        push_ent = {ex3_gpr, ex3_preg, ex3_gpr ? fspu_mfvr_data : fspu_forward_result};

        fspu_wb_vld = ~fifo_empty;
        pop         = fspu_wb_vld & wb_fspu_grant;
        {fspu_wb_gpr, fspu_wb_preg, fspu_wb_data} = fspu_wb_vld ? head_ent : '0;

        proto_err = ~rtu_yy_flush &
                    ((ex1_fspu_issue_vld & ~fspu_issue_allow) |
                     (fspu_forward_r_vld & (~ex3_vld | ex3_gpr)) |
                     (ex3_vld & ~ex3_gpr & ~fspu_forward_r_vld));
        err_d       = err_q | proto_err | fifo_ovf;
        fspu_wb_err = err_q;
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            trk_vld_q  <= '0;
            trk_gpr_q  <= '0;
            trk_preg_q <= '0;
            err_q      <= 1'b0;
        end else begin
            trk_vld_q  <= trk_vld_d;
            trk_gpr_q  <= trk_gpr_d;
            trk_preg_q <= trk_preg_d;
            err_q      <= err_d;
        end
    end

    ct_fspu_wb_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .push           (push),
        .wdata          (push_ent),
        .pop            (pop),
        .rdata          (head_ent),
        .count          (fifo_count),
        .full           (fifo_full),
        .empty          (fifo_empty),
        .ovf            (fifo_ovf)
    );

endmodule

// File: tb/tb_ct_fspu_wb_ctrl.sv
// Bench for ct_fspu_wb_ctrl: directed scenarios plus randomized traffic checked
// against a queue-based model of in-flight ops and FIFO contents.
module tb_ct_fspu_wb_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_vld;
    logic [6:0]  dst_preg;
    logic        dst_gpr;
    logic        flush;
    logic        r_vld;
    logic [63:0] fwd_res;
    logic [63:0] mfvr;
    logic        grant;
    logic        fspu_issue_allow;
    logic        fspu_wb_vld;
    logic        fspu_wb_gpr;
    logic [6:0]  fspu_wb_preg;
    logic [63:0] fspu_wb_data;
    logic        fspu_wb_err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ct_fspu_wb_ctrl dut (
        .forever_cpuclk      (clk),
        .cpurst_b            (rst_n),
        .ex1_fspu_issue_vld  (issue_vld),
        .ex1_fspu_dst_preg   (dst_preg),
        .ex1_fspu_dst_gpr    (dst_gpr),
        .rtu_yy_flush        (flush),
        .fspu_forward_r_vld  (r_vld),
        .fspu_forward_result (fwd_res),
        .fspu_mfvr_data      (mfvr),
        .fspu_issue_allow    (fspu_issue_allow),
        .fspu_wb_vld         (fspu_wb_vld),
        .fspu_wb_gpr         (fspu_wb_gpr),
        .fspu_wb_preg        (fspu_wb_preg),
        .fspu_wb_data        (fspu_wb_data),
        .wb_fspu_grant       (grant),
        .fspu_wb_err         (fspu_wb_err)
    );

    // Reference model: ops in flight carry their pipe stage (2 or 3); FIFO is a queue.
    typedef struct packed {
        logic        gpr;
        logic [6:0]  preg;
        logic [63:0] data;
    } ent_t;

    typedef struct {
        logic       gpr;
        logic [6:0] preg;
        int         stage;
    } op_t;

    ent_t m_fifo[$];
    op_t  m_fly[$];
    bit   m_err;
    ent_t exp_h;

    function automatic bit m_allow();
        return (m_fifo.size() + m_fly.size()) < DEPTH;
    endfunction

    function automatic bit m_ex3_fpr();
        foreach (m_fly[i]) if (m_fly[i].stage == 3 && !m_fly[i].gpr) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit   allow, has3;
        op_t  e3, o;
        op_t  nf[$];
        if (!rst_n) begin
            m_fifo.delete();
            m_fly.delete();
            m_err = 1'b0;
        end else begin
            allow = m_allow();
            has3  = 1'b0;
            e3    = '{1'b0, 7'd0, 0};
            foreach (m_fly[i]) if (m_fly[i].stage == 3) begin has3 = 1'b1; e3 = m_fly[i]; end
            if (!flush) begin
                if (issue_vld && !allow) m_err = 1'b1;
                if (r_vld && (!has3 || e3.gpr)) m_err = 1'b1;
                if (has3 && !e3.gpr && !r_vld) m_err = 1'b1;
            end
            if (m_fifo.size() != 0 && grant) void'(m_fifo.pop_front());
            if (has3 && !flush) begin
                if (m_fifo.size() == DEPTH) m_err = 1'b1;
                else m_fifo.push_back({e3.gpr, e3.preg, e3.gpr ? mfvr : fwd_res});
            end
            nf.delete();
            if (!flush) begin
                foreach (m_fly[i]) if (m_fly[i].stage < 3) begin
                    o = m_fly[i];
                    o.stage = o.stage + 1;
                    nf.push_back(o);
                end
                if (issue_vld && allow) nf.push_back('{dst_gpr, dst_preg, 2});
            end
            m_fly = nf;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_vld = 1'b0; dst_preg = '0; dst_gpr = 1'b0; flush = 1'b0;
        r_vld = 1'b0; fwd_res = '0; mfvr = '0; grant = 1'b0;
    endtask

    task automatic pulse_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        pulse_reset();
        @(negedge clk);
        vectors++; if (fspu_wb_vld !== 1'b0) begin miscompares++; $display("FAIL reset_vld got=%b exp=0", fspu_wb_vld); end
        vectors++; if (fspu_issue_allow !== 1'b1) begin miscompares++; $display("FAIL reset_allow got=%b exp=1", fspu_issue_allow); end
        vectors++; if (fspu_wb_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b exp=0", fspu_wb_err); end
        vectors++; if (fspu_wb_gpr !== 1'b0) begin miscompares++; $display("FAIL reset_gpr got=%b exp=0", fspu_wb_gpr); end
        vectors++; if (fspu_wb_preg !== 7'd0) begin miscompares++; $display("FAIL reset_preg got=%h exp=0", fspu_wb_preg); end
        vectors++; if (fspu_wb_data !== 64'd0) begin miscompares++; $display("FAIL reset_data got=%h exp=0", fspu_wb_data); end
        tick();
    endtask

    task automatic test_single_fpr();
        idle(); grant = 1'b1;
        issue_vld = 1'b1; dst_preg = 7'h12; dst_gpr = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++; if (fspu_wb_vld !== 1'b0) begin miscompares++; $display("FAIL fpr_early_vld cyc=%0d got=%b exp=0", c, fspu_wb_vld); end
            tick();
            issue_vld = 1'b0;
            r_vld   = (c == 1);
            fwd_res = (c == 1) ? 64'h3FF0_0000_0000_0000 : 64'h0;
        end
        @(negedge clk);
        vectors++; if (fspu_wb_vld !== 1'b1) begin miscompares++; $display("FAIL fpr_vld got=%b exp=1", fspu_wb_vld); end
        vectors++; if (fspu_wb_gpr !== 1'b0) begin miscompares++; $display("FAIL fpr_gpr got=%b exp=0", fspu_wb_gpr); end
        vectors++; if (fspu_wb_preg !== 7'h12) begin miscompares++; $display("FAIL fpr_preg got=%h exp=12", fspu_wb_preg); end
        vectors++; if (fspu_wb_data !== 64'h3FF0_0000_0000_0000) begin miscompares++; $display("FAIL fpr_data got=%h exp=3ff0000000000000", fspu_wb_data); end
        tick();
        @(negedge clk);
        vectors++; if (fspu_wb_vld !== 1'b0) begin miscompares++; $display("FAIL fpr_one_cycle got=%b exp=0", fspu_wb_vld); end
        vectors++; if (fspu_wb_err !== 1'b0) begin miscompares++; $display("FAIL fpr_err got=%b exp=0", fspu_wb_err); end
        tick();
    endtask

    task automatic test_mfvr();
        idle(); grant = 1'b1;
        issue_vld = 1'b1; dst_preg = 7'h05; dst_gpr = 1'b1;
        tick(); issue_vld = 1'b0;
        tick(); mfvr = 64'h0000_0000_DEAD_BEEF; fwd_res = 64'h1234_5678_9ABC_DEF0;
        tick(); mfvr = '0; fwd_res = '0;
        @(negedge clk);
        vectors++; if (fspu_wb_vld !== 1'b1) begin miscompares++; $display("FAIL mfvr_vld got=%b exp=1", fspu_wb_vld); end
        vectors++; if (fspu_wb_gpr !== 1'b1) begin miscompares++; $display("FAIL mfvr_gpr got=%b exp=1", fspu_wb_gpr); end
        vectors++; if (fspu_wb_preg !== 7'h05) begin miscompares++; $display("FAIL mfvr_preg got=%h exp=05", fspu_wb_preg); end
        vectors++; if (fspu_wb_data !== 64'hDEAD_BEEF) begin miscompares++; $display("FAIL mfvr_data got=%h exp=deadbeef", fspu_wb_data); end
        vectors++; if (fspu_wb_err !== 1'b0) begin miscompares++; $display("FAIL mfvr_err got=%b exp=0", fspu_wb_err); end
        tick();
    endtask

    task automatic test_fill();
        int accepted = 0;
        idle();
        for (int c = 0; c < 10; c++) begin
            issue_vld = fspu_issue_allow;
            dst_preg  = 7'(8'h20 + accepted);
            dst_gpr   = accepted[0];
            fwd_res   = {32'hF0F0_0000, 32'(c)};
            mfvr      = {32'hA5A5_0000, 32'(c)};
            r_vld     = m_ex3_fpr();
            if (issue_vld) accepted++;
            @(negedge clk);
            vectors++; if (fspu_issue_allow !== m_allow()) begin miscompares++; $display("FAIL fill_allow cyc=%0d got=%b exp=%b", c, fspu_issue_allow, m_allow()); end
            tick();
        end
        idle();
        vectors++; if (accepted != DEPTH) begin miscompares++; $display("FAIL fill_accepted got=%0d exp=%0d", accepted, DEPTH); end
        vectors++; if (fspu_issue_allow !== 1'b0) begin miscompares++; $display("FAIL fill_allow_low got=%b exp=0", fspu_issue_allow); end
        grant = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            exp_h = (m_fifo.size() != 0) ? m_fifo[0] : '0;
            vectors++; if (fspu_wb_vld !== 1'b1) begin miscompares++; $display("FAIL drain_vld k=%0d got=%b exp=1", k, fspu_wb_vld); end
            vectors++; if (fspu_wb_preg !== 7'(8'h20 + k)) begin miscompares++; $display("FAIL drain_preg k=%0d got=%h exp=%h", k, fspu_wb_preg, 7'(8'h20 + k)); end
            vectors++; if (fspu_wb_data !== exp_h.data) begin miscompares++; $display("FAIL drain_data k=%0d got=%h exp=%h", k, fspu_wb_data, exp_h.data); end
            tick();
        end
        @(negedge clk);
        vectors++; if (fspu_wb_vld !== 1'b0) begin miscompares++; $display("FAIL drain_empty got=%b exp=0", fspu_wb_vld); end
        vectors++; if (fspu_issue_allow !== 1'b1) begin miscompares++; $display("FAIL drain_allow got=%b exp=1", fspu_issue_allow); end
        vectors++; if (fspu_wb_err !== 1'b0) begin miscompares++; $display("FAIL fill_err got=%b exp=0", fspu_wb_err); end
        tick();
    endtask

    task automatic test_flush();
        idle();
        issue_vld = 1'b1; dst_preg = 7'h31; dst_gpr = 1'b1; mfvr = 64'h1111;
        tick(); issue_vld = 1'b0;
        repeat (3) tick();
        issue_vld = 1'b1; dst_preg = 7'h32; dst_gpr = 1'b0;
        tick(); dst_preg = 7'h33;
        tick(); dst_preg = 7'h34; flush = 1'b1; r_vld = 1'b1;
        tick(); issue_vld = 1'b0; flush = 1'b0; r_vld = 1'b0; grant = 1'b1;
        @(negedge clk);
        vectors++; if (fspu_wb_vld !== 1'b1) begin miscompares++; $display("FAIL flush_old_vld got=%b exp=1", fspu_wb_vld); end
        vectors++; if (fspu_wb_preg !== 7'h31) begin miscompares++; $display("FAIL flush_old_preg got=%h exp=31", fspu_wb_preg); end
        vectors++; if (fspu_wb_data !== 64'h1111) begin miscompares++; $display("FAIL flush_old_data got=%h exp=1111", fspu_wb_data); end
        tick(); grant = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vectors++; if (fspu_wb_vld !== 1'b0) begin miscompares++; $display("FAIL flush_no_push cyc=%0d got=%b exp=0", c, fspu_wb_vld); end
            tick();
        end
        vectors++; if (fspu_issue_allow !== 1'b1) begin miscompares++; $display("FAIL flush_allow got=%b exp=1", fspu_issue_allow); end
        vectors++; if (fspu_wb_err !== 1'b0) begin miscompares++; $display("FAIL flush_err got=%b exp=0", fspu_wb_err); end
    endtask

    task automatic test_random();
        idle();
        for (int c = 0; c < 400; c++) begin
            flush     = ($urandom_range(11) == 0);
            issue_vld = ($urandom_range(2) != 0) && m_allow();
            dst_preg  = 7'($urandom);
            dst_gpr   = 1'($urandom);
            grant     = 1'($urandom);
            fwd_res   = {$urandom, $urandom};
            mfvr      = {$urandom, $urandom};
            r_vld     = m_ex3_fpr();
            @(negedge clk);
            exp_h = (m_fifo.size() != 0) ? m_fifo[0] : '0;
            vectors++; if (fspu_wb_vld !== (m_fifo.size() != 0)) begin miscompares++; $display("FAIL rnd_vld cyc=%0d got=%b exp=%b", c, fspu_wb_vld, m_fifo.size() != 0); end
            vectors++; if (fspu_wb_gpr !== exp_h.gpr) begin miscompares++; $display("FAIL rnd_gpr cyc=%0d got=%b exp=%b", c, fspu_wb_gpr, exp_h.gpr); end
            vectors++; if (fspu_wb_preg !== exp_h.preg) begin miscompares++; $display("FAIL rnd_preg cyc=%0d got=%h exp=%h", c, fspu_wb_preg, exp_h.preg); end
            vectors++; if (fspu_wb_data !== exp_h.data) begin miscompares++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", c, fspu_wb_data, exp_h.data); end
            vectors++; if (fspu_issue_allow !== m_allow()) begin miscompares++; $display("FAIL rnd_allow cyc=%0d got=%b exp=%b", c, fspu_issue_allow, m_allow()); end
            vectors++; if (fspu_wb_err !== m_err) begin miscompares++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", c, fspu_wb_err, m_err); end
            tick();
        end
        idle();
    endtask

    task automatic test_err();
        pulse_reset();
        r_vld = 1'b1; flush = 1'b1;
        tick(); r_vld = 1'b0; flush = 1'b0;
        @(negedge clk);
        vectors++; if (fspu_wb_err !== 1'b0) begin miscompares++; $display("FAIL err_flush_suppress got=%b exp=0", fspu_wb_err); end
        tick(); r_vld = 1'b1;
        tick(); r_vld = 1'b0;
        @(negedge clk);
        vectors++; if (fspu_wb_err !== 1'b1) begin miscompares++; $display("FAIL err_stray_rvld got=%b exp=1", fspu_wb_err); end
        repeat (5) tick();
        vectors++; if (fspu_wb_err !== 1'b1) begin miscompares++; $display("FAIL err_sticky got=%b exp=1", fspu_wb_err); end
        vectors++; if (fspu_wb_err !== m_err) begin miscompares++; $display("FAIL err_model got=%b exp=%b", fspu_wb_err, m_err); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (fspu_wb_err !== 1'b0) begin miscompares++; $display("FAIL err_reset_clear got=%b exp=0", fspu_wb_err); end
        tick(); rst_n = 1'b1;
        dst_gpr = 1'b1;
        for (int c = 0; c < 8; c++) begin
            issue_vld = fspu_issue_allow;
            tick();
        end
        issue_vld = 1'b1;
        @(negedge clk);
        vectors++; if (fspu_wb_err !== 1'b0) begin miscompares++; $display("FAIL err_before_overissue got=%b exp=0", fspu_wb_err); end
        tick(); issue_vld = 1'b0;
        @(negedge clk);
        vectors++; if (fspu_wb_err !== 1'b1) begin miscompares++; $display("FAIL err_overissue got=%b exp=1", fspu_wb_err); end
        vectors++; if (fspu_wb_vld !== 1'b1) begin miscompares++; $display("FAIL err_fifo_kept got=%b exp=1", fspu_wb_vld); end
        tick();
    endtask

    task automatic test_async_reset();
        pulse_reset();
        dst_gpr = 1'b1; mfvr = 64'h5555_AAAA;
        issue_vld = 1'b1; dst_preg = 7'h41;
        tick(); dst_preg = 7'h42;
        tick(); issue_vld = 1'b0;
        tick(); issue_vld = 1'b1; dst_preg = 7'h43;
        tick(); issue_vld = 1'b0;
        @(negedge clk);
        vectors++; if (fspu_wb_vld !== 1'b1 || fspu_wb_preg !== 7'h41) begin miscompares++; $display("FAIL arst_pre vld=%b preg=%h exp=1/41", fspu_wb_vld, fspu_wb_preg); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (fspu_wb_vld !== 1'b0) begin miscompares++; $display("FAIL arst_vld got=%b exp=0", fspu_wb_vld); end
        vectors++; if (fspu_issue_allow !== 1'b1) begin miscompares++; $display("FAIL arst_allow got=%b exp=1", fspu_issue_allow); end
        vectors++; if (fspu_wb_preg !== 7'd0 || fspu_wb_data !== 64'd0 || fspu_wb_gpr !== 1'b0) begin miscompares++; $display("FAIL arst_fields got=%b/%h/%h exp=0/0/0", fspu_wb_gpr, fspu_wb_preg, fspu_wb_data); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++; if (fspu_wb_vld !== 1'b0 || fspu_wb_data !== 64'd0) begin miscompares++; $display("FAIL arst_stale cyc=%0d vld=%b data=%h exp=0/0", c, fspu_wb_vld, fspu_wb_data); end
            vectors++; if (fspu_issue_allow !== 1'b1) begin miscompares++; $display("FAIL arst_allow_after cyc=%0d got=%b exp=1", c, fspu_issue_allow); end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached, vectors=%0d miscompares=%0d", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_single_fpr();
        test_mfvr();
        test_fill();
        test_flush();
        test_random();
        test_err();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
